axis_demux: RTL and testbench
=============================

# axis_demux

Packet-level 1:2 demultiplexer for the 8-bit AXI-Stream path of the MII MAC; the receive-side counterpart of the transmit-path 2:1 packet mux. It steers each whole frame from the single stream input to output 0 or output 1, or discards it, according to a route code sampled at the frame's first beat. It keeps per-destination frame counters for link statistics. Output beats are registered, so each output is a full register stage.

## Interface
- COUNTER_WIDTH, 16, width of the three frame counters (wrapping).
- clock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- saxis_tdata  in  8  input byte.
- saxis_tvalid  in  1  input beat valid.
- saxis_tready  out  1  input beat accepted when high with tvalid.
- saxis_tuser  in  1  frame error flag, forwarded per beat.
- saxis_tlast  in  1  last byte of frame.
- route  in  2  destination of the frame: 0 = output 0, 1 = output 1, 2 or 3 = drop. Valid alongside the first beat of a frame.
- maxis_0_tdata / maxis_0_tvalid / maxis_0_tuser / maxis_0_tlast  out  8/1/1/1  output 0 stream (registered).
- maxis_0_tready  in  1  output 0 backpressure.
- maxis_1_tdata / maxis_1_tvalid / maxis_1_tuser / maxis_1_tlast  out  8/1/1/1  output 1 stream (registered).
- maxis_1_tready  in  1  output 1 backpressure.
- frame_count_0 / frame_count_1 / drop_count  out  COUNTER_WIDTH  frames delivered to output 0 / output 1 / frames discarded.

## Operation
States and transitions:
- IDLE: saxis_tready = 0. If saxis_tvalid = 1, sample route. Next state is ROUTE0 for route 0, ROUTE1 for route 1, and DROP for route 2 or 3. route is ignored while saxis_tvalid = 0.
- ROUTE0: saxis_tready = !maxis_0_tvalid || maxis_0_tready. On an accepted beat:
  - Load maxis_0_tdata, tuser and tlast from the input, and set maxis_0_tvalid = 1.
  - If saxis_tlast = 1, increment frame_count_0 and go to IDLE.
- ROUTE1: same as ROUTE0, using output 1 and frame_count_1.
- DROP: saxis_tready = 1. Accepted beats are discarded and no output changes. On an accepted beat with tlast = 1, increment drop_count and go to IDLE.

Output registers:
- Each maxis_N_tvalid clears when maxis_N_tvalid && maxis_N_tready, unless it is reloaded in the same cycle. Reload takes priority, so valid stays 1.
- The two output registers are independent. A completed frame may still be draining on output 0 while the next frame is being loaded into output 1.
- In states other than ROUTEN, maxis_N_tdata, tuser and tlast hold their values.

Frame and counter rules:
- tuser is forwarded unchanged. Frames with tuser set are still routed and counted normally.
- A frame is one beat or more. A single-beat frame goes IDLE -> ROUTEx -> IDLE.
- Counters wrap from 2^COUNTER_WIDTH-1 to 0. They are never saturated and never cleared, except by reset.

Reset:
- On reset: state = IDLE, maxis_0_tvalid = maxis_1_tvalid = 0, all counters = 0.
- maxis_N_tdata, tuser and tlast are reset to 0.
- saxis_tready is 0 during reset and in the first cycle after it.
- Reset mid-frame discards the in-flight output beats. The remainder of the upstream frame is then treated as a new frame, routed by route at its next beat.

## Timing
- Each frame has one IDLE cycle before its first beat can be accepted: saxis_tready is 0 in that cycle. The minimum gap between frames is therefore one cycle.
- Latency from input accept to maxis_N_tvalid = 1 is one cycle.
- Full throughput (one beat per cycle) within a frame while maxis_N_tready = 1.
- Under backpressure there is no beat loss and no duplication. saxis_tready follows the output register's combinational state.
- Counter updates are visible one cycle after the tlast beat is accepted.
- A route change during a frame has no effect.

## Test plan
- Route 0, 4-byte frame 0x11..0x14, both treadys high -> maxis_0 emits 0x11,0x12,0x13,0x14 on consecutive cycles with tlast on 0x14; maxis_1_tvalid stays 0; frame_count_0 = 1.
- Route 1 frame of 3 bytes with maxis_1_tready low for 5 cycles mid-frame -> all 3 bytes delivered in order, none duplicated; saxis_tready low while the output register is full; frame_count_1 = 1.
- Route 2 frame of 6 bytes -> saxis_tready = 1 for all 6 beats after IDLE; no output tvalid; drop_count = 1.
- Back-to-back frames routed 0 then 1 with maxis_0_tready held low -> output 0 holds its last beat valid while frame 2 streams fully to output 1.
- Set COUNTER_WIDTH = 2 and send 5 single-beat route-0 frames with tuser = 1 -> each emitted with tuser = 1 and tlast = 1; frame_count_0 reads 1 (wrapped).
- Assert reset for one cycle mid-frame while maxis_0_tvalid = 1 -> next cycle maxis_0_tvalid = 0, counters = 0, state IDLE; the next beat is routed by its own route value.

Source files
------------

// File: rtl/axis_demux.sv
// -----------------------------------------------------------------------------
// axis_demux
//
// Packet-level 1:2 demultiplexer for the 8-bit AXI-Stream receive path of the
// MII MAC. Each frame is steered as a whole to output 0 or output 1, or it is
// discarded. The choice is made from the route code that is present with the
// frame's first beat. Both outputs are full register stages. Three wrapping
// counters record how many frames went to each destination.
//
// Handshake: a beat transfers on any rising edge where tvalid and tready are
// both high. A source holds tvalid, tdata, tuser and tlast stable until that
// transfer happens. tready may depend combinationally on the state of the
// receiver.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   saxis_*               upstream stream (tdata/tvalid/tuser/tlast in,
//                         tready out)
//   route                 destination code sampled in IDLE:
//                         0 -> out 0, 1 -> out 1, 2/3 -> drop
//   maxis_0_*, maxis_1_*  registered downstream streams (tready in)
//   frame_count_0/1       frames delivered to output 0 / output 1
//   drop_count            frames discarded
//   state                 current FSM state, for debug and checkers
//                         (0 IDLE, 1 ROUTE0, 2 ROUTE1, 3 DROP)
// -----------------------------------------------------------------------------
module axis_demux #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic [7:0]               saxis_tdata,
    input  logic                     saxis_tvalid,
    output logic                     saxis_tready,
    input  logic                     saxis_tuser,
    input  logic                     saxis_tlast,
    input  logic [1:0]               route,

    output logic [7:0]               maxis_0_tdata,
    output logic                     maxis_0_tvalid,
    output logic                     maxis_0_tuser,
    output logic                     maxis_0_tlast,
    input  logic                     maxis_0_tready,

    output logic [7:0]               maxis_1_tdata,
    output logic                     maxis_1_tvalid,
    output logic                     maxis_1_tuser,
    output logic                     maxis_1_tlast,
    input  logic                     maxis_1_tready,

    output logic [COUNTER_WIDTH-1:0] frame_count_0,
    output logic [COUNTER_WIDTH-1:0] frame_count_1,
    output logic [COUNTER_WIDTH-1:0] drop_count,

    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2,
        DROP   = 2'd3
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    state_t state_q;
    logic   accept;
    logic   out0_free;
    logic   out1_free;

    assign state = state_q;

    // An output register can take a new beat when it is empty, or when its
    // current beat is leaving in this same cycle.
    assign out0_free = !maxis_0_tvalid || maxis_0_tready;
    assign out1_free = !maxis_1_tvalid || maxis_1_tready;

    // tready is forced low while reset is asserted, so that no beat is
    // consumed while the pipeline is being cleared.
    always_comb begin
        saxis_tready = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:    saxis_tready = 1'b0;
                ROUTE0:  saxis_tready = out0_free;
                ROUTE1:  saxis_tready = out1_free;
                DROP:    saxis_tready = 1'b1;
                default: saxis_tready = 1'b0;
            endcase
        end
    end

    assign accept = saxis_tvalid && saxis_tready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            maxis_0_tdata  <= 8'h00;
            maxis_0_tvalid <= 1'b0;
            maxis_0_tuser  <= 1'b0;
            maxis_0_tlast  <= 1'b0;
            maxis_1_tdata  <= 8'h00;
            maxis_1_tvalid <= 1'b0;
            maxis_1_tuser  <= 1'b0;
            maxis_1_tlast  <= 1'b0;
            frame_count_0  <= '0;
            frame_count_1  <= '0;
            drop_count     <= '0;
        end else begin
            // Drain first. A reload further down in the same cycle overrides
            // this clear, so a beat that arrives as the old one leaves keeps
            // tvalid high.
            if (maxis_0_tvalid && maxis_0_tready) begin
                maxis_0_tvalid <= 1'b0;
            end
            if (maxis_1_tvalid && maxis_1_tready) begin
                maxis_1_tvalid <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // The route code is only meaningful while a first beat is
                    // being offered.
                    if (saxis_tvalid) begin
                        case (route)
                            2'd0:    state_q <= ROUTE0;
                            2'd1:    state_q <= ROUTE1;
                            default: state_q <= DROP;
                        endcase
                    end
                end

                ROUTE0: begin
                    if (accept) begin
                        maxis_0_tdata  <= saxis_tdata;
                        maxis_0_tuser  <= saxis_tuser;
                        maxis_0_tlast  <= saxis_tlast;
                        maxis_0_tvalid <= 1'b1;
                        if (saxis_tlast) begin
                            frame_count_0 <= frame_count_0 + COUNT_ONE;
                            state_q       <= IDLE;
                        end
                    end
                end

                ROUTE1: begin
                    if (accept) begin
                        maxis_1_tdata  <= saxis_tdata;
                        maxis_1_tuser  <= saxis_tuser;
                        maxis_1_tlast  <= saxis_tlast;
                        maxis_1_tvalid <= 1'b1;
                        if (saxis_tlast) begin
                            frame_count_1 <= frame_count_1 + COUNT_ONE;
                            state_q       <= IDLE;
                        end
                    end
                end

                DROP: begin
                    if (accept && saxis_tlast) begin
                        drop_count <= drop_count + COUNT_ONE;
                        state_q    <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_demux.sv
// -----------------------------------------------------------------------------
// tb_axis_demux
//
// Directed bench for axis_demux. It uses COUNTER_WIDTH = 2 so that counter
// wrap can be reached quickly. Inputs change 1 time unit after a rising edge.
// Outputs and tready are read 1 unit later, so no read is ever made near an
// active edge.
// -----------------------------------------------------------------------------
module tb_axis_demux;
    localparam int CW = 2;

    logic          clock;
    logic          reset;
    logic [7:0]    saxis_tdata;
    logic          saxis_tvalid;
    logic          saxis_tready;
    logic          saxis_tuser;
    logic          saxis_tlast;
    logic [1:0]    route;
    logic [7:0]    maxis_0_tdata;
    logic          maxis_0_tvalid;
    logic          maxis_0_tuser;
    logic          maxis_0_tlast;
    logic          maxis_0_tready;
    logic [7:0]    maxis_1_tdata;
    logic          maxis_1_tvalid;
    logic          maxis_1_tuser;
    logic          maxis_1_tlast;
    logic          maxis_1_tready;
    logic [CW-1:0] frame_count_0;
    logic [CW-1:0] frame_count_1;
    logic [CW-1:0] drop_count;
    logic [1:0]    state;

    int vectors;
    int miscompares;

    axis_demux #(.COUNTER_WIDTH(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .saxis_tdata    (saxis_tdata),
        .saxis_tvalid   (saxis_tvalid),
        .saxis_tready   (saxis_tready),
        .saxis_tuser    (saxis_tuser),
        .saxis_tlast    (saxis_tlast),
        .route          (route),
        .maxis_0_tdata  (maxis_0_tdata),
        .maxis_0_tvalid (maxis_0_tvalid),
        .maxis_0_tuser  (maxis_0_tuser),
        .maxis_0_tlast  (maxis_0_tlast),
        .maxis_0_tready (maxis_0_tready),
        .maxis_1_tdata  (maxis_1_tdata),
        .maxis_1_tvalid (maxis_1_tvalid),
        .maxis_1_tuser  (maxis_1_tuser),
        .maxis_1_tlast  (maxis_1_tlast),
        .maxis_1_tready (maxis_1_tready),
        .frame_count_0  (frame_count_0),
        .frame_count_1  (frame_count_1),
        .drop_count     (drop_count),
        .state          (state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic u,
                         input logic l, input logic [1:0] r);
        saxis_tvalid = v;
        saxis_tdata  = d;
        saxis_tuser  = u;
        saxis_tlast  = l;
        route        = r;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        maxis_0_tready = 1'b1;
        maxis_1_tready = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        next_cycle();
        next_cycle();
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 2'd0);
        vectors++;
        if (saxis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tready: got %b exp 0", saxis_tready);
        end
        vectors++;
        if ({maxis_0_tvalid, maxis_1_tvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_valids: got %b exp 00", {maxis_0_tvalid, maxis_1_tvalid});
        end
        vectors++;
        if ({frame_count_0, frame_count_1, drop_count} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_counts: got %h %h %h exp 0 0 0", frame_count_0, frame_count_1, drop_count);
        end
        vectors++;
        if ({maxis_0_tdata, maxis_0_tuser, maxis_0_tlast, maxis_1_tdata, maxis_1_tuser, maxis_1_tlast} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h exp 00 00", maxis_0_tdata, maxis_1_tdata);
        end
        vectors++;
        if (state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d exp 0", state);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        next_cycle();
        #1;
        vectors++;
        if (saxis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_tready: got %b exp 0", saxis_tready);
        end
    endtask

    task automatic test_route0();
        logic [7:0] exp_d;
        drive(1'b1, 8'h11, 1'b0, 1'b0, 2'd0);
        vectors++;
        if (saxis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_idle_tready: got %b exp 0", saxis_tready);
        end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'h11 + 8'(i);
            drive(1'b1, exp_d, 1'b0, (i == 3), 2'd0);
            vectors++;
            if (saxis_tready !== 1'b1) begin
                miscompares++;
                $display("FAIL r0_tready beat %0d: got %b exp 1", i, saxis_tready);
            end
            if (i > 0) begin
                vectors++;
                if ({maxis_0_tvalid, maxis_0_tdata, maxis_0_tlast} !== {1'b1, exp_d - 8'h01, 1'b0}) begin
                    miscompares++;
                    $display("FAIL r0_out beat %0d: got v%b %h l%b exp v1 %h l0", i - 1,
                             maxis_0_tvalid, maxis_0_tdata, maxis_0_tlast, exp_d - 8'h01);
                end
            end
            vectors++;
            if (maxis_1_tvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL r0_out1_quiet: got %b exp 0", maxis_1_tvalid);
            end
            next_cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        vectors++;
        if ({maxis_0_tvalid, maxis_0_tdata, maxis_0_tlast} !== {1'b1, 8'h14, 1'b1}) begin
            miscompares++;
            $display("FAIL r0_last: got v%b %h l%b exp v1 14 l1", maxis_0_tvalid, maxis_0_tdata, maxis_0_tlast);
        end
        vectors++;
        if (frame_count_0 !== 2'd1) begin
            miscompares++;
            $display("FAIL r0_count: got %0d exp 1", frame_count_0);
        end
        next_cycle();
        vectors++;
        if ({maxis_0_tvalid, state} !== {1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL r0_drain: got v%b s%0d exp v0 s0", maxis_0_tvalid, state);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 8'hA1, 1'b0, 1'b0, 2'd1);
        next_cycle();
        vectors++;
        if (saxis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_first_tready: got %b exp 1", saxis_tready);
        end
        next_cycle();
        // Stall the output. The route code is changed to 0 mid-frame, and
        // this must have no effect.
        maxis_1_tready = 1'b0;
        drive(1'b1, 8'hA2, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({saxis_tready, maxis_1_tvalid, maxis_1_tdata} !== {1'b0, 1'b1, 8'hA1}) begin
                miscompares++;
                $display("FAIL bp_stall cycle %0d: got rdy%b v%b %h exp rdy0 v1 a1", i,
                         saxis_tready, maxis_1_tvalid, maxis_1_tdata);
            end
            next_cycle();
        end
        maxis_1_tready = 1'b1;
        #1;
        vectors++;
        if (saxis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_tready: got %b exp 1", saxis_tready);
        end
        next_cycle();
        drive(1'b1, 8'hA3, 1'b0, 1'b1, 2'd0);
        vectors++;
        if ({maxis_1_tvalid, maxis_1_tdata, maxis_0_tvalid} !== {1'b1, 8'hA2, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_second: got v%b %h out0v%b exp v1 a2 out0v0", maxis_1_tvalid, maxis_1_tdata, maxis_0_tvalid);
        end
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        vectors++;
        if ({maxis_1_tvalid, maxis_1_tdata, maxis_1_tlast, maxis_1_tuser} !== {1'b1, 8'hA3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_third: got v%b %h l%b u%b exp v1 a3 l1 u0", maxis_1_tvalid, maxis_1_tdata,
                     maxis_1_tlast, maxis_1_tuser);
        end
        vectors++;
        if ({frame_count_1, maxis_0_tvalid} !== {2'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_count: got %0d out0v%b exp 1 out0v0", frame_count_1, maxis_0_tvalid);
        end
        next_cycle();
        vectors++;
        if (maxis_1_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: got %b exp 0", maxis_1_tvalid);
        end
    endtask

    task automatic test_drop();
        maxis_0_tready = 1'b0;
        maxis_1_tready = 1'b0;
        drive(1'b1, 8'h30, 1'b0, 1'b0, 2'd2);
        vectors++;
        if (saxis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_idle_tready: got %b exp 0", saxis_tready);
        end
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h30 + 8'(i), 1'b0, (i == 5), 2'd0);
            vectors++;
            if ({saxis_tready, maxis_0_tvalid, maxis_1_tvalid} !== 3'b100) begin
                miscompares++;
                $display("FAIL drop_beat %0d: got rdy%b v0%b v1%b exp rdy1 v0 v0", i,
                         saxis_tready, maxis_0_tvalid, maxis_1_tvalid);
            end
            next_cycle();
        end
        // A single-beat frame with route 3 follows straight after.
        drive(1'b1, 8'h3F, 1'b1, 1'b1, 2'd3);
        vectors++;
        if ({drop_count, state} !== {2'd1, 2'd0}) begin
            miscompares++;
            $display("FAIL drop_count1: got %0d s%0d exp 1 s0", drop_count, state);
        end
        next_cycle();
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        vectors++;
        if ({drop_count, maxis_0_tvalid, maxis_1_tvalid, maxis_0_tdata} !== {2'd2, 1'b0, 1'b0, 8'h14}) begin
            miscompares++;
            $display("FAIL drop_count2: got %0d v0%b v1%b d0 %h exp 2 v0 v0 14", drop_count,
                     maxis_0_tvalid, maxis_1_tvalid, maxis_0_tdata);
        end
        maxis_1_tready = 1'b1;
    endtask

    task automatic test_back_to_back();
        maxis_0_tready = 1'b0;
        drive(1'b1, 8'h41, 1'b0, 1'b1, 2'd0);
        next_cycle();
        next_cycle();
        // The route-1 frame is offered right away, inside the mandatory
        // IDLE cycle.
        drive(1'b1, 8'h51, 1'b0, 1'b0, 2'd1);
        vectors++;
        if ({saxis_tready, maxis_0_tvalid, maxis_0_tdata, frame_count_0} !== {1'b0, 1'b1, 8'h41, 2'd2}) begin
            miscompares++;
            $display("FAIL b2b_gap: got rdy%b v%b %h c%0d exp rdy0 v1 41 c2", saxis_tready,
                     maxis_0_tvalid, maxis_0_tdata, frame_count_0);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h51 + 8'(i), 1'b0, (i == 2), 2'd1);
            vectors++;
            if ({saxis_tready, maxis_0_tvalid, maxis_0_tdata, maxis_0_tlast} !== {1'b1, 1'b1, 8'h41, 1'b1}) begin
                miscompares++;
                $display("FAIL b2b_hold beat %0d: got rdy%b v%b %h l%b exp rdy1 v1 41 l1", i,
                         saxis_tready, maxis_0_tvalid, maxis_0_tdata, maxis_0_tlast);
            end
            if (i > 0) begin
                vectors++;
                if ({maxis_1_tvalid, maxis_1_tdata} !== {1'b1, 8'h50 + 8'(i)}) begin
                    miscompares++;
                    $display("FAIL b2b_out1 beat %0d: got v%b %h exp v1 %h", i - 1,
                             maxis_1_tvalid, maxis_1_tdata, 8'h50 + 8'(i));
                end
            end
            next_cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        vectors++;
        if ({maxis_1_tvalid, maxis_1_tdata, maxis_1_tlast, frame_count_1} !== {1'b1, 8'h53, 1'b1, 2'd2}) begin
            miscompares++;
            $display("FAIL b2b_last: got v%b %h l%b c%0d exp v1 53 l1 c2", maxis_1_tvalid,
                     maxis_1_tdata, maxis_1_tlast, frame_count_1);
        end
        maxis_0_tready = 1'b1;
        next_cycle();
        vectors++;
        if ({maxis_0_tvalid, maxis_1_tvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_drain: got %b exp 00", {maxis_0_tvalid, maxis_1_tvalid});
        end
    endtask

    task automatic test_reset_midframe();
        drive(1'b1, 8'h71, 1'b0, 1'b0, 2'd0);
        next_cycle();
        next_cycle();
        drive(1'b1, 8'h72, 1'b0, 1'b0, 2'd0);
        maxis_0_tready = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if ({maxis_0_tvalid, saxis_tready} !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_pre: got v%b rdy%b exp v1 rdy0", maxis_0_tvalid, saxis_tready);
        end
        next_cycle();
        reset = 1'b0;
        maxis_0_tready = 1'b1;
        drive(1'b1, 8'h72, 1'b0, 1'b1, 2'd1);
        vectors++;
        if ({maxis_0_tvalid, state, saxis_tready} !== {1'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_after: got v%b s%0d rdy%b exp v0 s0 rdy0", maxis_0_tvalid, state, saxis_tready);
        end
        vectors++;
        if ({frame_count_0, frame_count_1, drop_count} !== 6'd0) begin
            miscompares++;
            $display("FAIL mid_counts: got %0d %0d %0d exp 0 0 0", frame_count_0, frame_count_1, drop_count);
        end
        next_cycle();
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        vectors++;
        if ({maxis_1_tvalid, maxis_1_tdata, maxis_0_tvalid, frame_count_1} !== {1'b1, 8'h72, 1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL mid_reroute: got v1%b %h v0%b c%0d exp v1 72 v0 c1", maxis_1_tvalid,
                     maxis_1_tdata, maxis_0_tvalid, frame_count_1);
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'h60 + 8'(k), 1'b1, 1'b1, 2'd0);
            next_cycle();
            vectors++;
            if (saxis_tready !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_tready frame %0d: got %b exp 1", k, saxis_tready);
            end
            next_cycle();
            vectors++;
            if ({maxis_0_tvalid, maxis_0_tdata, maxis_0_tuser, maxis_0_tlast} !== {1'b1, 8'h60 + 8'(k), 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL wrap_out frame %0d: got v%b %h u%b l%b exp v1 %h u1 l1", k, maxis_0_tvalid,
                         maxis_0_tdata, maxis_0_tuser, maxis_0_tlast, 8'h60 + 8'(k));
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        vectors++;
        if (frame_count_0 !== 2'd1) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d exp 1", frame_count_0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_route0();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_reset_midframe();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
